// File: rtl/wb_master_engine.sv
// ============================================================================
// Module   : wb_master_engine
// Purpose  : Wishbone classic master engine. Takes single or burst commands,
//            streams write/read beats, and handles retries and aborts.
//            Optional bus timeout: define WB_MASTER_ENGINE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_engine #(
   parameter int AW        = 16,
   parameter int DW        = 32,
   parameter int LW        = 4,
   parameter int MAX_RETRY = 3
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
   ,
   parameter int TIMEOUT   = 255
`endif
) (
   input  logic            CLK_I,
   input  logic            RST_I,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_we,
   input  logic [AW-1:0]   cmd_adr,
   input  logic [DW/8-1:0] cmd_sel,
   input  logic [LW-1:0]   cmd_len,
   input  logic            wd_valid,
   output logic            wd_ready,
   input  logic [DW-1:0]   wd_data,
   output logic            rd_valid,
   output logic [DW-1:0]   rd_data,
   output logic            done,
   output logic            err,
   output logic [1:0]      err_code,
   output logic [AW-1:0]   ADR_O,
   output logic            CYC_O,
   output logic            STB_O,
   output logic            WE_O,
   output logic [DW/8-1:0] SEL_O,
   output logic [DW-1:0]   DAT_O,
   input  logic [DW-1:0]   DAT_I,
   input  logic            ACK_I,
   input  logic            ERR_I,
   input  logic            RTY_I
);

   localparam logic [1:0]    c_IDLE  = 2'd0;
   localparam logic [1:0]    c_BUS   = 2'd1;
   localparam logic [1:0]    c_RETRY = 2'd2;
   localparam logic [1:0]    c_DONE  = 2'd3;
   localparam logic [AW-1:0] c_STEP  = AW'(DW / 8);
   localparam int            c_RW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   logic [1:0]      r_state;
   logic [1:0]      w_next;
   logic [LW-1:0]   r_beats;
   logic [c_RW-1:0] r_retry;

   logic w_accept;
   logic w_err_hit;
   logic w_rty_hit;
   logic w_ack_hit;
   logic w_to_hit;
   logic w_abort;
   logic w_last;
   logic [1:0] w_abort_code;

   // Responses only count while strobing; ERR beats RTY beats ACK.
   assign w_accept     = cmd_valid & cmd_ready;
   assign w_err_hit    = STB_O & ERR_I;
   assign w_rty_hit    = STB_O & ~ERR_I & RTY_I;
   assign w_ack_hit    = STB_O & ~ERR_I & ~RTY_I & ACK_I;
   assign w_abort      = w_err_hit | (w_rty_hit & (r_retry == c_RW'(MAX_RETRY))) | w_to_hit;
   assign w_last       = w_ack_hit & (r_beats == '0);
   assign w_abort_code = w_err_hit ? 2'b01 : (w_rty_hit ? 2'b10 : 2'b11);

`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
   localparam int c_TW = $clog2(TIMEOUT + 1);
   logic [c_TW-1:0] r_to_cnt;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I)
         r_to_cnt <= '0;
      else if (!STB_O || ACK_I || ERR_I || RTY_I)
         r_to_cnt <= '0;
      else
         r_to_cnt <= r_to_cnt + c_TW'(1);
   end

   // Fires on the TIMEOUT-th consecutive silent strobe cycle.
   assign w_to_hit = STB_O & ~(ACK_I | ERR_I | RTY_I) & (r_to_cnt == c_TW'(TIMEOUT - 1));
`else
   assign w_to_hit = 1'b0;
`endif

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I)
         r_state <= c_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_next = c_BUS;
         c_BUS: begin
            if (w_abort || w_last)
               w_next = c_DONE;
            else if (w_rty_hit)
               w_next = c_RETRY;
         end
         c_RETRY: w_next = c_BUS;
         c_DONE:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      wd_ready  = 1'b0;
      cmd_ready = (r_state == c_IDLE) & ~RST_I;
      wd_ready  = (r_state == c_BUS) & CYC_O & WE_O & ~STB_O;
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         ADR_O    <= '0;
         CYC_O    <= 1'b0;
         STB_O    <= 1'b0;
         WE_O     <= 1'b0;
         SEL_O    <= '0;
         DAT_O    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= 2'b00;
         r_beats  <= '0;
         r_retry  <= '0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  CYC_O    <= 1'b1;
                  STB_O    <= ~cmd_we;
                  WE_O     <= cmd_we;
                  ADR_O    <= cmd_adr;
                  SEL_O    <= cmd_sel;
                  r_beats  <= cmd_len;
                  r_retry  <= '0;
                  err_code <= 2'b00;
               end
            end
            c_BUS: begin
               if (w_abort) begin
                  CYC_O    <= 1'b0;
                  STB_O    <= 1'b0;
                  WE_O     <= 1'b0;
                  done     <= 1'b1;
                  err      <= 1'b1;
                  err_code <= w_abort_code;
               end else if (w_rty_hit) begin
                  CYC_O   <= 1'b0;
                  STB_O   <= 1'b0;
                  r_retry <= r_retry + c_RW'(1);
               end else if (w_ack_hit) begin
                  ADR_O   <= ADR_O + c_STEP;
                  r_beats <= r_beats - LW'(1);
                  r_retry <= '0;
                  if (!WE_O) begin
                     rd_valid <= 1'b1;
                     rd_data  <= DAT_I;
                  end
                  if (r_beats == '0) begin
                     CYC_O <= 1'b0;
                     STB_O <= 1'b0;
                     WE_O  <= 1'b0;
                     done  <= 1'b1;
                  end else if (WE_O) begin
                     STB_O <= 1'b0;
                  end
               end else if (wd_valid && wd_ready) begin
                  DAT_O <= wd_data;
                  STB_O <= 1'b1;
               end
            end
            // Re-issue the same beat; address and data are untouched.
            c_RETRY: begin
               CYC_O <= 1'b1;
               STB_O <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_master_engine.sv
// ============================================================================
// Module   : tb_wb_master_engine
// Purpose  : Self-checking bench for wb_master_engine (scripted slave + model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_master_engine;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam int MAX_RETRY = 3;
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
   localparam int TIMEOUT = 8;
`endif

   localparam int c_WAIT = 1;
   localparam int c_ACK  = 2;
   localparam int c_RTY  = 3;
   localparam int c_ERR  = 4;
   localparam int c_ALL  = 5;

   logic CLK_I = 1'b0;
   logic RST_I;
   logic cmd_valid, cmd_ready, cmd_we;
   logic [AW-1:0] cmd_adr;
   logic [DW/8-1:0] cmd_sel;
   logic [LW-1:0] cmd_len;
   logic wd_valid, wd_ready;
   logic [DW-1:0] wd_data;
   logic rd_valid;
   logic [DW-1:0] rd_data;
   logic done, err;
   logic [1:0] err_code;
   logic [AW-1:0] ADR_O;
   logic CYC_O, STB_O, WE_O;
   logic [DW/8-1:0] SEL_O;
   logic [DW-1:0] DAT_O, DAT_I;
   logic ACK_I, ERR_I, RTY_I;

   wb_master_engine #(
      .AW(AW), .DW(DW), .LW(LW), .MAX_RETRY(MAX_RETRY)
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
      , .TIMEOUT(TIMEOUT)
`endif
   ) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .done(done), .err(err), .err_code(err_code),
      .ADR_O(ADR_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
      .SEL_O(SEL_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
      .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
   );

   always #5 CLK_I = ~CLK_I;

   int checks = 0;
   int failures = 0;

   // Slave response script: one code per strobed cycle.
   int scr [256];
   int scr_n = 0;
   int scr_p = 0;

   logic [DW-1:0] wdat [16];
   int wd_n = 0;
   int wd_idx = 0;
   bit gap_en = 0;
   bit gapped = 0;
   bit dead_mode = 0;

   bit active = 0;
   bit started = 0;
   bit done_seen = 0;
   int cyc_cnt = 0;
   int gap_cnt = 0;
   int done_cnt = 0;
   logic obs_err;
   logic [1:0] obs_code;

   logic [AW-1:0]   ack_adr [$];
   logic [DW-1:0]   ack_dato [$];
   logic [DW-1:0]   ack_dati [$];
   logic [DW/8-1:0] ack_sel [$];
   logic [DW-1:0]   rd_q [$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Monitor, scripted slave and write-data source, all on the falling edge.
   always @(negedge CLK_I) begin
      int c;
      if (done) done_cnt++;
      if (active) begin
         if (CYC_O) begin
            cyc_cnt++;
            started = 1;
         end else if (started && !done_seen && !done) begin
            gap_cnt++;
         end
         if (rd_valid) rd_q.push_back(rd_data);
         if (done && !done_seen) begin
            done_seen = 1;
            obs_err   = err;
            obs_code  = err_code;
         end
      end

      ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
      if (STB_O) begin
         c = (scr_p < scr_n) ? scr[scr_p] : c_WAIT;
         if (scr_p < scr_n) scr_p++;
         DAT_I = dead_mode ? 32'hDEADBEEF : $urandom;
         case (c)
            c_ACK: begin
               ACK_I = 1'b1;
               ack_adr.push_back(ADR_O);
               ack_dato.push_back(DAT_O);
               ack_dati.push_back(DAT_I);
               ack_sel.push_back(SEL_O);
            end
            c_RTY: RTY_I = 1'b1;
            c_ERR: ERR_I = 1'b1;
            c_ALL: begin ACK_I = 1'b1; ERR_I = 1'b1; RTY_I = 1'b1; end
            default: ;
         endcase
      end else begin
         // Junk responses while not strobing must be ignored.
         {ACK_I, ERR_I, RTY_I} = 3'($urandom);
         DAT_I = $urandom;
      end

      if (active && wd_idx < wd_n) begin
         if (gap_en && wd_idx == 2 && !gapped && wd_ready) begin
            wd_valid = 1'b0;
            gapped   = 1;
         end else begin
            wd_valid = 1'b1;
            wd_data  = wdat[wd_idx];
            if (wd_ready) wd_idx++;
         end
      end else begin
         wd_valid = 1'b0;
      end
   end

   // Reference: walk the script beat by beat applying the protocol rules.
   function automatic void model(input logic we, input logic [3:0] len,
                                 output int beats, output int wd_used,
                                 output logic e, output logic [1:0] code);
      int p, tries, waits, c;
      bit fin;
      p = 0; beats = 0; wd_used = 0; e = 1'b0; code = 2'b00; waits = 0;
      for (int b = 0; b <= int'(len) && !e; b++) begin
         tries = 0;
         fin = 0;
         if (we) wd_used++;
         while (!fin && !e) begin
            c = (p < scr_n) ? scr[p] : c_WAIT;
            p++;
            if (c == c_WAIT) begin
               waits++;
`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
               if (waits == TIMEOUT) begin e = 1'b1; code = 2'b11; end
`else
               if (waits > 1000) begin e = 1'b1; code = 2'b00; end
`endif
            end else begin
               waits = 0;
               if (c == c_ACK) begin
                  beats++;
                  fin = 1;
               end else if (c == c_RTY) begin
                  tries++;
                  if (tries > MAX_RETRY) begin e = 1'b1; code = 2'b10; end
               end else begin
                  e = 1'b1; code = 2'b01;
               end
            end
         end
      end
   endfunction

   function automatic void load_nib(input logic [47:0] s);
      logic [47:0] v;
      v = s;
      scr_n = 0;
      while (v[3:0] != 4'd0 && scr_n < 12) begin
         scr[scr_n] = int'(v[3:0]);
         scr_n++;
         v = v >> 4;
      end
   endfunction

   task automatic do_reset();
      RST_I = 1'b1;
      active = 0;
      cmd_valid = 1'b0;
      repeat (2) @(negedge CLK_I);
      #1 RST_I = 1'b0;
   endtask

   task automatic run_cmd(input string nm, input logic we, input logic [15:0] adr,
                          input logic [3:0] len, input logic [3:0] sel, input bit gap,
                          input int t_cyc, input int t_gaps, input int t_err,
                          input int t_code, input int t_beats);
      int m_beats, m_wd, n;
      logic m_err;
      logic [1:0] m_code;
      logic [15:0] ea;
      model(we, len, m_beats, m_wd, m_err, m_code);
      @(negedge CLK_I);
      #1;
      for (int i = 0; i < 16; i++) wdat[i] = $urandom;
      wd_n = we ? int'(len) + 1 : 0;
      wd_idx = 0; gapped = 0; gap_en = gap;
      ack_adr.delete(); ack_dato.delete(); ack_dati.delete(); ack_sel.delete(); rd_q.delete();
      scr_p = 0; started = 0; done_seen = 0; cyc_cnt = 0; gap_cnt = 0;
      check({nm, "_ready_before"}, cmd_ready, 1'b1);
      cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_sel = sel;
      cmd_valid = 1'b1;
      active = 1;
      @(negedge CLK_I);
      #1 cmd_valid = 1'b0;
      n = 0;
      while (!done_seen && n < 3000) begin
         @(negedge CLK_I);
         #1 n++;
      end
      if (!done_seen) begin
         check({nm, "_done_timeout"}, 0, 1);
         do_reset();
         return;
      end
      @(negedge CLK_I);
      #1;
      check({nm, "_ready_after"}, cmd_ready, 1'b1);
      check({nm, "_done_single"}, done, 1'b0);
      check({nm, "_code_held"}, err_code, m_code);
      active = 0;
      check({nm, "_err"}, obs_err, m_err);
      check({nm, "_code"}, obs_code, m_code);
      check({nm, "_acks"}, ack_adr.size(), m_beats);
      for (int k = 0; k < ack_adr.size() && k < m_beats; k++) begin
         ea = adr + 16'(4 * k);
         check($sformatf("%s_adr%0d", nm, k), ack_adr[k], ea);
         check($sformatf("%s_sel%0d", nm, k), ack_sel[k], sel);
         if (we) check($sformatf("%s_dato%0d", nm, k), ack_dato[k], wdat[k]);
         else if (k < rd_q.size()) check($sformatf("%s_rd%0d", nm, k), rd_q[k], ack_dati[k]);
      end
      if (we) check({nm, "_wd_used"}, wd_idx, m_wd);
      else    check({nm, "_rd_count"}, rd_q.size(), m_beats);
      if (t_err >= 0) begin
         check({nm, "_t_err"}, obs_err, t_err);
         check({nm, "_t_code"}, obs_code, t_code);
         check({nm, "_t_beats"}, ack_adr.size(), t_beats);
         check({nm, "_t_cyc"}, cyc_cnt, t_cyc);
         check({nm, "_t_gaps"}, gap_cnt, t_gaps);
      end
   endtask

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [3:0]  len;
      logic [3:0]  sel;
      bit          gap;
      logic [47:0] scr;
      int          cyc;
      int          gaps;
      int          e;
      int          code;
      int          beats;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int nb, r, base;
      logic [3:0] rl;
      tbl[0] = '{1'b0, 16'h0100, 4'd0, 4'hF, 1'b0, 48'h211,  3, 0, 0, 0, 1};
      tbl[1] = '{1'b1, 16'hFFF8, 4'd3, 4'hF, 1'b1, 48'h2222, 9, 0, 0, 0, 4};
      tbl[2] = '{1'b0, 16'h0200, 4'd0, 4'h3, 1'b0, 48'h23,   2, 1, 0, 0, 1};
      tbl[3] = '{1'b0, 16'h0300, 4'd1, 4'hF, 1'b0, 48'h3333, 4, 3, 1, 2, 0};
      tbl[4] = '{1'b0, 16'h0400, 4'd3, 4'hF, 1'b0, 48'h42,   2, 0, 1, 1, 1};
      tbl[5] = '{1'b0, 16'h0500, 4'd0, 4'hF, 1'b0, 48'h5,    1, 0, 1, 1, 0};
      tbl[6] = '{1'b1, 16'h0010, 4'd1, 4'hC, 1'b0, 48'h232,  5, 1, 0, 0, 2};
      tbl[7] = '{1'b1, 16'h0020, 4'd2, 4'hF, 1'b0, 48'h4,    2, 0, 1, 1, 0};

      RST_I = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
      wd_valid = 1'b0; wd_data = '0; DAT_I = '0; ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
      repeat (3) @(negedge CLK_I);
      #1;
      check("rst_cmd_ready", cmd_ready, 1'b0);
      check("rst_cyc", CYC_O, 1'b0);
      check("rst_stb", STB_O, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err_code", err_code, 2'b00);
      check("rst_adr", ADR_O, 16'h0000);
      check("rst_wd_ready", wd_ready, 1'b0);
      RST_I = 1'b0;
      @(negedge CLK_I);
      #1 check("idle_cmd_ready", cmd_ready, 1'b1);

      for (int i = 0; i < 8; i++) begin
         load_nib(tbl[i].scr);
         dead_mode = (i == 0);
         run_cmd($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].len, tbl[i].sel,
                 tbl[i].gap, tbl[i].cyc, tbl[i].gaps, tbl[i].e, tbl[i].code, tbl[i].beats);
      end
      dead_mode = 0;

`ifdef WB_MASTER_ENGINE_TIMEOUT_EN
      load_nib(48'h0);
      run_cmd("timeout", 1'b0, 16'h0600, 4'd0, 4'hF, 1'b0, 8, 0, 1, 3, 0);
`endif

      // Reset in the middle of a burst with a silent slave.
      load_nib(48'h1111);
      @(negedge CLK_I);
      #1;
      scr_p = 0; started = 0; done_seen = 0;
      cmd_we = 1'b0; cmd_adr = 16'h0700; cmd_len = 4'd3; cmd_sel = 4'hF;
      cmd_valid = 1'b1; active = 1;
      @(negedge CLK_I);
      #1 cmd_valid = 1'b0;
      repeat (2) @(negedge CLK_I);
      base = done_cnt;
      #2 RST_I = 1'b1;
      #1;
      check("rst_mid_cyc", CYC_O, 1'b0);
      check("rst_mid_stb", STB_O, 1'b0);
      check("rst_mid_ready", cmd_ready, 1'b0);
      @(negedge CLK_I);
      #1 RST_I = 1'b0;
      active = 0;
      repeat (4) @(negedge CLK_I);
      #1;
      check("rst_mid_no_done", done_cnt, base);
      check("rst_mid_idle", cmd_ready, 1'b1);

      // Random commands against the reference model.
      for (int t = 0; t < 40; t++) begin
         rl = 4'($urandom_range(0, 15));
         scr_n = 0;
         for (int b = 0; b <= int'(rl); b++) begin
            repeat ($urandom_range(0, 2)) begin scr[scr_n] = c_WAIT; scr_n++; end
            r = $urandom_range(0, 19);
            nb = (r < 12) ? 0 : (r < 17) ? int'($urandom_range(1, 3)) : (r < 19) ? 4 : 0;
            for (int k = 0; k < nb; k++) begin
               scr[scr_n] = c_RTY; scr_n++;
               if ($urandom_range(0, 1) == 1) begin scr[scr_n] = c_WAIT; scr_n++; end
            end
            scr[scr_n] = (r == 19) ? (($urandom_range(0, 1) == 1) ? c_ERR : c_ALL) : c_ACK;
            scr_n++;
         end
         run_cmd($sformatf("rnd%0d", t), 1'($urandom), 16'($urandom), rl,
                 4'($urandom_range(1, 15)), ($urandom_range(0, 1) == 1), -1, -1, -1, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
